// File: rtl/usb_bus_state_ctrl.sv
// Device-side USB full-speed bus event controller.
// Synchronizes and debounces the decoded line state, times SE0 and J runs,
// and sequences ACTIVE / BUS_RESET / SUSPEND / RESUME for the receiver.
module usb_bus_state_ctrl #(
  parameter int unsigned FILT_CYCLES    = 2,
  parameter int unsigned RESET_CYCLES   = 120,
  parameter int unsigned SUSPEND_CYCLES = 144000,
  parameter int unsigned CNT_W          = 18
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] usb_line_state,
  output logic [1:0] line_filt_o,
  output logic [1:0] bus_state_o,
  output logic       rx_en_o,
  output logic       bus_reset_o,
  output logic       suspend_o,
  output logic       resume_o,
  output logic       se1_err_o
);

  localparam int unsigned FCW = $clog2(FILT_CYCLES + 1);

  localparam logic [1:0] LineSe0 = 2'b00;
  localparam logic [1:0] LineJ   = 2'b01;
  localparam logic [1:0] LineK   = 2'b10;
  localparam logic [1:0] LineSe1 = 2'b11;

  // "Held N" is detected as the run counter sitting at N-1.
  localparam logic [CNT_W-1:0] ResetHeld   = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] SuspendHeld = CNT_W'(SUSPEND_CYCLES - 1);
  localparam logic [FCW-1:0]   FiltDone    = FCW'(FILT_CYCLES);

  typedef enum logic [1:0] {
    StActive   = 2'd0,
    StBusReset = 2'd1,
    StSuspend  = 2'd2,
    StResume   = 2'd3
  } bus_state_e;

  logic [1:0]       sync1_q, sync2_q;
  logic [1:0]       line_filt_q, line_filt_d;
  logic [1:0]       cand_q, cand_d;
  logic [FCW-1:0]   filt_cnt_q, filt_cnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  bus_state_e       state_q, state_d;
  logic             rx_en_q, rx_en_d;
  logic             bus_reset_q, bus_reset_d;
  logic             suspend_q, suspend_d;
  logic             resume_q, resume_d;
  logic             se1_err_q, se1_err_d;

  // Debounce: count consecutive cycles of one value that differs from the filtered state.
  always_comb begin
    line_filt_d = line_filt_q;
    cand_d      = cand_q;
    filt_cnt_d  = filt_cnt_q;
    if (sync2_q == line_filt_q) begin
      filt_cnt_d = '0;
    end else if (filt_cnt_q != '0 && sync2_q != cand_q) begin
      // A different new value restarts the count; this cycle already counts once.
      filt_cnt_d = FCW'(1);
      cand_d     = sync2_q;
    end else if (filt_cnt_q + FCW'(1) == FiltDone) begin
      line_filt_d = sync2_q;
      filt_cnt_d  = '0;
    end else begin
      filt_cnt_d = filt_cnt_q + FCW'(1);
      cand_d     = sync2_q;
    end
  end

  // Run counter: restarts on every filtered change, saturates instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (line_filt_d != line_filt_q) begin
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Synchronizer, filter and run counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= LineJ;
      sync2_q     <= LineJ;
      line_filt_q <= LineJ;
      cand_q      <= LineJ;
      filt_cnt_q  <= '0;
      cnt_q       <= '0;
    end else begin
      sync1_q     <= usb_line_state;
      sync2_q     <= sync1_q;
      line_filt_q <= line_filt_d;
      cand_q      <= cand_d;
      filt_cnt_q  <= filt_cnt_d;
      cnt_q       <= cnt_d;
    end
  end

  // Link-state transitions, judged on the current filtered line and run count.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StActive: begin
        if (line_filt_q == LineSe0 && cnt_q == ResetHeld) begin
          state_d = StBusReset;
        end else if (line_filt_q == LineJ && cnt_q == SuspendHeld) begin
          state_d = StSuspend;
        end
      end
      StBusReset: begin
        if (line_filt_q != LineSe0) state_d = StActive;
      end
      StSuspend: begin
        if (line_filt_q == LineK) begin
          state_d = StResume;
        end else if (line_filt_q == LineSe0 && cnt_q == ResetHeld) begin
          state_d = StBusReset;
        end
      end
      StResume: begin
        if (line_filt_q != LineK) state_d = StActive;
      end
    endcase
  end

  // Output next-values derived from the next state so they register alongside it.
  always_comb begin
    rx_en_d     = (state_d == StActive);
    bus_reset_d = (state_d == StBusReset) && (state_q != StBusReset);
    suspend_d   = (state_d == StSuspend);
    resume_d    = (state_d == StResume) && (state_q == StSuspend);
    se1_err_d   = (line_filt_d == LineSe1) && (line_filt_q != LineSe1);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StActive;
      rx_en_q     <= 1'b1;
      bus_reset_q <= 1'b0;
      suspend_q   <= 1'b0;
      resume_q    <= 1'b0;
      se1_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_en_q     <= rx_en_d;
      bus_reset_q <= bus_reset_d;
      suspend_q   <= suspend_d;
      resume_q    <= resume_d;
      se1_err_q   <= se1_err_d;
    end
  end

  assign line_filt_o = line_filt_q;
  assign bus_state_o = state_q;
  assign rx_en_o     = rx_en_q;
  assign bus_reset_o = bus_reset_q;
  assign suspend_o   = suspend_q;
  assign resume_o    = resume_q;
  assign se1_err_o   = se1_err_q;

endmodule

// File: tb/tb_usb_bus_state_ctrl.sv
// Directed bench for usb_bus_state_ctrl. Expected output values are queued with
// the cycle at which they must hold and checked on the falling edge of that cycle.
module tb_usb_bus_state_ctrl;

  localparam int SelFilt  = 0;
  localparam int SelState = 1;
  localparam int SelRxEn  = 2;
  localparam int SelBRst  = 3;
  localparam int SelSusp  = 4;
  localparam int SelRes   = 5;
  localparam int SelSe1   = 6;

  typedef struct {
    string       tag;
    int unsigned cyc;
    int          sel;
    logic [1:0]  val;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] usb_line_state = 2'b01;
  logic [1:0] line_filt_o;
  logic [1:0] bus_state_o;
  logic       rx_en_o, bus_reset_o, suspend_o, resume_o, se1_err_o;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          tests = 0;
  int          fails = 0;
  logic        done = 1'b0;
  logic [1:0]  obs;

  usb_bus_state_ctrl #(
    .FILT_CYCLES   (2),
    .RESET_CYCLES  (8),
    .SUSPEND_CYCLES(32),
    .CNT_W         (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .usb_line_state(usb_line_state),
    .line_filt_o   (line_filt_o),
    .bus_state_o   (bus_state_o),
    .rx_en_o       (rx_en_o),
    .bus_reset_o   (bus_reset_o),
    .suspend_o     (suspend_o),
    .resume_o      (resume_o),
    .se1_err_o     (se1_err_o)
  );

  always #5 clk = ~clk;

  // cyc == n from just after the n-th rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [1:0] get_obs(input int sel);
    case (sel)
      SelFilt:  return line_filt_o;
      SelState: return bus_state_o;
      SelRxEn:  return {1'b0, rx_en_o};
      SelBRst:  return {1'b0, bus_reset_o};
      SelSusp:  return {1'b0, suspend_o};
      SelRes:   return {1'b0, resume_o};
      default:  return {1'b0, se1_err_o};
    endcase
  endfunction

  // Pop and compare every expectation due in this cycle.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        obs = get_obs(sb[i].sel);
        tests++;
        assert (obs === sb[i].val)
        else begin
          fails++;
          $error("FAIL %s sel=%0d cyc=%0d observed=%0h expected=%0h",
                 sb[i].tag, sb[i].sel, cyc, obs, sb[i].val);
        end
        sb.delete(i);
      end
    end
    if (done) begin
      tests++;
      assert (sb.size() == 0)
      else begin
        fails++;
        $error("FAIL leftover_expectations observed=%0d expected=0", sb.size());
      end
    end
  end

  task automatic push(input string tag, input int unsigned c, input int sel,
                      input logic [1:0] v);
    exp_t e;
    e.tag = tag;
    e.cyc = c;
    e.sel = sel;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic push_win(input string tag, input int unsigned c0, input int unsigned c1,
                          input int sel, input logic [1:0] v);
    for (int unsigned c = c0; c <= c1; c++) push(tag, c, sel, v);
  endtask

  task automatic push_idle(input string tag, input int unsigned c0, input int unsigned c1);
    push_win(tag, c0, c1, SelFilt, 2'b01);
    push_win(tag, c0, c1, SelState, 2'd0);
    push_win(tag, c0, c1, SelRxEn, 2'd1);
    push_win(tag, c0, c1, SelBRst, 2'd0);
    push_win(tag, c0, c1, SelSusp, 2'd0);
    push_win(tag, c0, c1, SelRes, 2'd0);
    push_win(tag, c0, c1, SelSe1, 2'd0);
  endtask

  // Change an input just after rising edge n.
  task automatic wait_cyc(input int unsigned n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values.
    push_idle("reset", 2, 3);
    wait_cyc(3);
    rst = 1'b0;

    // One-cycle K glitch on idle J is filtered out.
    push_idle("glitch", 5, 14);
    wait_cyc(5);
    usb_line_state = 2'b10;
    wait_cyc(6);
    usb_line_state = 2'b01;

    // Long SE0: filtered at +4, bus reset 8 cycles later, back to ACTIVE after J.
    push("rst_filt_pre", 18, SelFilt, 2'b01);
    push("rst_filt", 19, SelFilt, 2'b00);
    push("rst_pulse_pre", 26, SelBRst, 2'd0);
    push("rst_pulse", 27, SelBRst, 2'd1);
    push_win("rst_pulse_once", 28, 38, SelBRst, 2'd0);
    push("rst_state_pre", 26, SelState, 2'd0);
    push_win("rst_state", 27, 39, SelState, 2'd1);
    push("rst_rxen_pre", 26, SelRxEn, 2'd1);
    push_win("rst_rxen", 27, 39, SelRxEn, 2'd0);
    push("rst_filt_j", 39, SelFilt, 2'b01);
    push("rst_exit_state", 40, SelState, 2'd0);
    push("rst_exit_rxen", 40, SelRxEn, 2'd1);
    wait_cyc(15);
    usb_line_state = 2'b00;
    wait_cyc(35);
    usb_line_state = 2'b01;

    // Short SE0 (6 filtered cycles) does not qualify.
    push("short_filt", 49, SelFilt, 2'b00);
    push("short_filt_j", 55, SelFilt, 2'b01);
    push_win("short_state", 45, 60, SelState, 2'd0);
    push_win("short_brst", 45, 60, SelBRst, 2'd0);
    wait_cyc(45);
    usb_line_state = 2'b00;
    wait_cyc(51);
    usb_line_state = 2'b01;

    // Suspend after 32 filtered J cycles, resume on K, then SE0 returns to ACTIVE.
    push("susp_pre", 86, SelSusp, 2'd0);
    push("susp_state_pre", 86, SelState, 2'd0);
    push_win("susp_level", 87, 95, SelSusp, 2'd1);
    push_win("susp_state", 87, 95, SelState, 2'd2);
    push("susp_rxen", 87, SelRxEn, 2'd0);
    push("res_filt", 95, SelFilt, 2'b10);
    push("res_pulse_pre", 95, SelRes, 2'd0);
    push("res_pulse", 96, SelRes, 2'd1);
    push("res_pulse_end", 97, SelRes, 2'd0);
    push("res_susp_fall", 96, SelSusp, 2'd0);
    push_win("res_state", 96, 105, SelState, 2'd3);
    push("res_se0", 105, SelFilt, 2'b00);
    push("res_j", 107, SelFilt, 2'b01);
    push_win("res_exit_state", 106, 110, SelState, 2'd0);
    push("res_exit_rxen", 106, SelRxEn, 2'd1);
    wait_cyc(91);
    usb_line_state = 2'b10;
    wait_cyc(101);
    usb_line_state = 2'b00;
    wait_cyc(103);
    usb_line_state = 2'b01;

    // Reset from suspend.
    push_win("rfs_state_susp", 139, 156, SelState, 2'd2);
    push_win("rfs_susp", 139, 156, SelSusp, 2'd1);
    push("rfs_filt", 149, SelFilt, 2'b00);
    push("rfs_susp_fall", 157, SelSusp, 2'd0);
    push("rfs_pulse_pre", 156, SelBRst, 2'd0);
    push("rfs_pulse", 157, SelBRst, 2'd1);
    push("rfs_pulse_end", 158, SelBRst, 2'd0);
    push_win("rfs_state", 157, 161, SelState, 2'd1);
    push("rfs_exit_state", 162, SelState, 2'd0);
    push("rfs_exit_rxen", 162, SelRxEn, 2'd1);
    wait_cyc(145);
    usb_line_state = 2'b00;
    wait_cyc(157);
    usb_line_state = 2'b01;

    // SE1 flags an error once and leaves the state alone.
    push("se1_filt", 169, SelFilt, 2'b11);
    push("se1_filt_j", 174, SelFilt, 2'b01);
    push_win("se1_pre", 165, 168, SelSe1, 2'd0);
    push("se1_pulse", 169, SelSe1, 2'd1);
    push_win("se1_once", 170, 176, SelSe1, 2'd0);
    push_win("se1_state", 165, 176, SelState, 2'd0);
    push_win("se1_rxen", 165, 176, SelRxEn, 2'd1);
    wait_cyc(165);
    usb_line_state = 2'b11;
    wait_cyc(170);
    usb_line_state = 2'b01;

    // rst during BUS_RESET restores reset values; SE0 is then re-filtered and re-timed.
    push("mid_filt", 184, SelFilt, 2'b00);
    push("mid_pulse", 192, SelBRst, 2'd1);
    push_win("mid_state", 192, 194, SelState, 2'd1);
    push_idle("mid_rst", 195, 198);
    push("mid_refilt", 199, SelFilt, 2'b00);
    push_win("mid_retime", 199, 206, SelState, 2'd0);
    push("mid_pulse2", 207, SelBRst, 2'd1);
    push("mid_state2", 207, SelState, 2'd1);
    wait_cyc(180);
    usb_line_state = 2'b00;
    wait_cyc(194);
    rst = 1'b1;
    wait_cyc(195);
    rst = 1'b0;
    wait_cyc(210);
    usb_line_state = 2'b01;

    wait_cyc(220);
    done = 1'b1;
    @(negedge clk);
    @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
